// File: rtl/mem_scan_ctrl_pkg.sv
// Shared types and constants for the memory scan controller.
package mem_scan_pkg;

  localparam int MEM_WORDS   = 128;
  localparam int ADDR_W_DFLT = $clog2(MEM_WORDS);
  localparam int DATA_W_DFLT = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WR_SUM = 3'd2,
    WR_MAX = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_scan_ctrl_scan_acc.sv
// Wrapping-sum / unsigned-max accumulator for the scan controller.
// The max register and its compare exist only when MEM_SCAN_MAX_EN is defined.
module scan_acc
  import mem_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
`ifdef MEM_SCAN_MAX_EN
  output logic [DATA_W-1:0] max,
`endif
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (clr) begin
      r_sum <= '0;
    end else if (en) begin
      r_sum <= r_sum + din;
    end
  end

  assign sum = r_sum;

`ifdef MEM_SCAN_MAX_EN
  logic [DATA_W-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
    end else if (clr) begin
      r_max <= '0;
    end else if (en && (din > r_max)) begin
      r_max <= din;
    end
  end

  assign max = r_max;
`endif

endmodule

// File: rtl/mem_scan_ctrl.sv
// Sweeps a word range of the 128x32 memory, writes sum (and max) back, pulses done.
// Optional: MEM_SCAN_MAX_EN adds the max accumulator and the WR_MAX write cycle.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// READ   | index=ptr, accumulate rd_data each edge, cnt counts down to 1
// WR_SUM | write sum to dst
// WR_MAX | write max to dst+1 (MEM_SCAN_MAX_EN only)
// DONE   | one-cycle done pulse
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] index,
  output logic              write,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] rd_data
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_cnt;
  logic              w_accept;
  logic              w_acc_en;
  logic [DATA_W-1:0] w_sum;
`ifdef MEM_SCAN_MAX_EN
  logic [DATA_W-1:0] w_max;
`endif

  assign w_accept = (r_state == IDLE) && start;
  assign w_acc_en = (r_state == READ);

  scan_acc #(.DATA_W(DATA_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_acc_en),
    .din   (rd_data),
`ifdef MEM_SCAN_MAX_EN
    .max   (w_max),
`endif
    .sum   (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ptr <= base;
        r_cnt <= len;
        r_dst <= dst;
      end else if (r_state == READ) begin
        r_ptr <= r_ptr + ADDR_W'(1);
        r_cnt <= r_cnt - (ADDR_W+1)'(1);
      end
    end
  end

  // Outputs decode only flops (state, ptr, dst, accumulators); rd_data never reaches a port.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    index       = '0;
    write       = 1'b0;
    write_data  = '0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (len == '0) ? WR_SUM : READ;
      end
      READ: begin
        busy  = 1'b1;
        index = r_ptr;
        if (r_cnt == (ADDR_W+1)'(1)) w_state_nxt = WR_SUM;
      end
      WR_SUM: begin
        busy       = 1'b1;
        index      = r_dst;
        write      = 1'b1;
        write_data = w_sum;
`ifdef MEM_SCAN_MAX_EN
        w_state_nxt = WR_MAX;
`else
        w_state_nxt = DONE;
`endif
      end
`ifdef MEM_SCAN_MAX_EN
      WR_MAX: begin
        busy        = 1'b1;
        index       = r_dst + ADDR_W'(1);
        write       = 1'b1;
        write_data  = w_max;
        w_state_nxt = DONE;
      end
`endif
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Self-checking bench for mem_scan_ctrl with a behavioural 128x32 memory and reference model.
module tb_mem_scan_ctrl;
  import mem_scan_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;
`ifdef MEM_SCAN_MAX_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] dst = '0;
  logic          busy, done, write;
  logic [AW-1:0] index;
  logic [DW-1:0] write_data, rd_data;

  logic [DW-1:0] mem [MEM_WORDS];
  int checks = 0;
  int errors = 0;

  mem_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len), .dst(dst),
    .busy(busy), .done(done), .index(index), .write(write),
    .write_data(write_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  assign rd_data = mem[index];
  always @(posedge clk) if (write) mem[index] <= write_data;

  task automatic fill_random();
    for (int i = 0; i < MEM_WORDS; i++)
      mem[i] <= ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    @(negedge clk);
  endtask

  // Reference: sum and max over the wrapped range, taken from a pre-op snapshot.
  task automatic run_op(input logic [AW-1:0] b, input logic [AW:0] n,
                        input logic [AW-1:0] d, input string tag);
    logic [DW-1:0] snap [MEM_WORDS];
    logic [DW-1:0] expm [MEM_WORDS];
    logic [DW-1:0] s, m;
    logic [AW-1:0] d1;
    int exp_k, exp_wr, done_k, nwr, bad;
    for (int i = 0; i < MEM_WORDS; i++) snap[i] = mem[i];
    s = 0; m = 0;
    for (int i = 0; i < int'(n); i++) begin
      logic [DW-1:0] w;
      w = snap[(int'(b) + i) % MEM_WORDS];
      s = s + w;
      if (w > m) m = w;
    end
    d1 = d + 7'd1;
    for (int i = 0; i < MEM_WORDS; i++) expm[i] = snap[i];
    expm[d] = s;
    if (MAXEN) expm[d1] = m;
    exp_k  = int'(n) + (MAXEN ? 3 : 2);
    exp_wr = MAXEN ? 2 : 1;

    @(negedge clk);
    base = b; len = n; dst = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_k = -1; nwr = 0;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_k1: got %b want 1", tag, busy);
        end
      end
      if (k == int'(n) + 1) begin
        checks++;
        if (write !== 1'b1 || index !== d || write_data !== s) begin
          errors++;
          $display("FAIL %s wr_sum: got wr=%b idx=%0d data=%h want wr=1 idx=%0d data=%h",
                   tag, write, index, write_data, d, s);
        end
      end
      if (MAXEN && k == int'(n) + 2) begin
        checks++;
        if (write !== 1'b1 || index !== d1 || write_data !== m) begin
          errors++;
          $display("FAIL %s wr_max: got wr=%b idx=%0d data=%h want wr=1 idx=%0d data=%h",
                   tag, write, index, write_data, d1, m);
        end
      end
      if (write === 1'b1) nwr++;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k != exp_k) begin
      errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_k, exp_k);
    end
    checks++;
    if (nwr != exp_wr) begin
      errors++; $display("FAIL %s write_count: got %0d want %0d", tag, nwr, exp_wr);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_after: got busy=%b done=%b want 0 0", tag, busy, done);
    end
    bad = -1;
    for (int i = 0; i < MEM_WORDS; i++) if (bad < 0 && mem[i] !== expm[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s mem[%0d]: got %h want %h", tag, bad, mem[bad], expm[bad]);
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] snap [MEM_WORDS];
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || write !== 1'b0 || index !== '0 || write_data !== '0) begin
      errors++;
      $display("FAIL reset_vals: got busy=%b done=%b wr=%b idx=%0d data=%h want all 0",
               busy, done, write, index, write_data);
    end
    rst_n = 1'b1;
    fill_random();
    for (int i = 0; i < MEM_WORDS; i++) snap[i] = mem[i];
    base = 7'd0; len = 8'd64; dst = 7'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || index !== 7'd9) begin
      errors++; $display("FAIL midread_state: got busy=%b idx=%0d want 1 9", busy, index);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b wr=%b done=%b want 0 0 0", busy, write, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bad = -1;
    for (int i = 0; i < MEM_WORDS; i++) if (bad < 0 && mem[i] !== snap[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++; $display("FAIL reset_nowrite mem[%0d]: got %h want %h", bad, mem[bad], snap[bad]);
    end
    run_op(7'd3, 8'd5, 7'd60, "post_reset");
  endtask

  task automatic test_basic();
    fill_random();
    for (int i = 0; i < 4; i++) mem[i] <= 32'(i + 1);
    @(negedge clk);
    run_op(7'd0, 8'd4, 7'd100, "basic");
    checks++;
    if (mem[100] !== 32'd10 || (MAXEN && mem[101] !== 32'd4)) begin
      errors++; $display("FAIL basic_vals: got %0d %0d want 10 4", mem[100], mem[101]);
    end
  endtask

  task automatic test_wrap();
    fill_random();
    mem[126] <= 32'd5; mem[127] <= 32'hFFFF_FFFF; mem[0] <= 32'd7; mem[1] <= 32'd1;
    @(negedge clk);
    run_op(7'd126, 8'd4, 7'd10, "wrap");
    checks++;
    if (mem[10] !== 32'h0000_000C || (MAXEN && mem[11] !== 32'hFFFF_FFFF)) begin
      errors++; $display("FAIL wrap_vals: got %h %h want 0000000c ffffffff", mem[10], mem[11]);
    end
  endtask

  task automatic test_len0();
    fill_random();
    run_op(7'd40, 8'd0, 7'd127, "len0");
    checks++;
    if (mem[127] !== 32'd0 || (MAXEN && mem[0] !== 32'd0)) begin
      errors++; $display("FAIL len0_vals: got %h %h want 0 0", mem[127], mem[0]);
    end
  endtask

  task automatic test_overlap();
    fill_random();
    mem[20] <= 32'd3; mem[21] <= 32'd9;
    @(negedge clk);
    run_op(7'd20, 8'd2, 7'd20, "overlap");
    checks++;
    if (mem[20] !== 32'd12 || mem[21] !== 32'd9) begin
      errors++; $display("FAIL overlap_vals: got %0d %0d want 12 9", mem[20], mem[21]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] s, m;
    int exp_k, done_k, nwr;
    fill_random();
    s = 0; m = 0;
    for (int i = 0; i < 8; i++) begin
      s = s + mem[i];
      if (mem[i] > m) m = mem[i];
    end
    exp_k = 8 + (MAXEN ? 3 : 2);
    @(negedge clk);
    base = 7'd0; len = 8'd8; dst = 7'd50; start = 1'b1;
    done_k = -1; nwr = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (write === 1'b1) nwr++;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k != exp_k || nwr != (MAXEN ? 2 : 1)) begin
      errors++;
      $display("FAIL held_start: got done_k=%0d writes=%0d want %0d %0d",
               done_k, nwr, exp_k, MAXEN ? 2 : 1);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL gap_idle: got busy=%b want 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || index !== 7'd0) begin
      errors++; $display("FAIL reaccept: got busy=%b idx=%0d want 1 0", busy, index);
    end
    done_k = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    checks++;
    if (done_k != exp_k || mem[50] !== s || (MAXEN && mem[51] !== m)) begin
      errors++;
      $display("FAIL second_op: got done_k=%0d sum=%h max=%h want %0d %h %h",
               done_k, mem[50], mem[51], exp_k, s, m);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      logic [AW-1:0] b, d;
      logic [AW:0]   n;
      fill_random();
      b = 7'($urandom_range(0, 127));
      d = 7'($urandom_range(0, 127));
      n = 8'($urandom_range(0, 128));
      run_op(b, n, d, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_overlap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
